// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads opcode and 0-2 argument bytes from synchronous
// program memory and hands complete instructions to execute via valid/ready.
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            opcode,
    input  logic [1:0]            argc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [1:0]            instr_argc,
    output logic [15:0]           instr_args,
    input  logic                  branch_taken,
    input  logic [15:0]           branch_offset
);

    typedef enum logic [2:0] {
        OPREQ,
        OPCAP,
        DEC,
        ARG2,
        VALID
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [7:0]            opcode_next;
    logic [15:0]           args_next;
    logic [1:0]            argc_next;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic                  accept;

    // Signed size cast sign-extends for wide pcs and truncates for narrow ones.
    assign offset_ext  = ADDR_WIDTH'($signed(branch_offset));
    assign accept      = (state == VALID) && instr_ready;
    assign instr_valid = (state == VALID);
    assign instr_pc    = pc;

    always_comb begin
        mem_addr = pc;
        case (state)
            OPCAP:   mem_addr = pc + ADDR_WIDTH'(1);
            DEC:     mem_addr = pc + ADDR_WIDTH'(2);
            default: mem_addr = pc;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        opcode_next = opcode;
        args_next   = instr_args;
        argc_next   = instr_argc;
        case (state)
            OPREQ: state_next = OPCAP;
            OPCAP: begin
                opcode_next = mem_rdata;
                args_next   = '0;
                state_next  = DEC;
            end
            DEC: begin
                case (argc)
                    2'd1: begin
                        argc_next  = 2'd1;
                        args_next  = {8'h00, mem_rdata};
                        state_next = VALID;
                    end
                    2'd2: begin
                        argc_next       = 2'd2;
                        args_next[15:8] = mem_rdata;
                        state_next      = ARG2;
                    end
                    // Undefined count 3 is fetched as a zero-argument opcode.
                    default: begin
                        argc_next  = 2'd0;
                        state_next = VALID;
                    end
                endcase
            end
            ARG2: begin
                args_next[7:0] = mem_rdata;
                state_next     = VALID;
            end
            VALID: begin
                if (accept) begin
                    if (branch_taken) pc_next = pc + offset_ext;
                    else              pc_next = pc + ADDR_WIDTH'(1) + ADDR_WIDTH'(instr_argc);
                    state_next = OPREQ;
                end
            end
            default: state_next = OPREQ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OPREQ;
            pc         <= RESET_PC;
            opcode     <= 8'h00;
            instr_args <= '0;
            instr_argc <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            opcode     <= opcode_next;
            instr_args <= args_next;
            instr_argc <= argc_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 16-bit-address instance runs a small program,
// a 4-bit-address instance covers reset during ARG2 and address wrap.
module tb_instr_fetch;

    logic clk;
    logic rst, rst_b;

    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, opcode;
    logic [1:0]  argc, instr_argc;
    logic        instr_valid, instr_ready, branch_taken;
    logic [15:0] instr_pc, instr_args, branch_offset;

    logic [3:0]  mem_addr_b, instr_pc_b;
    logic [7:0]  mem_rdata_b, opcode_b;
    logic [1:0]  argc_b, instr_argc_b;
    logic        instr_valid_b, instr_ready_b, branch_taken_b;
    logic [15:0] instr_args_b, branch_offset_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [16];

    int checks = 0;
    int errors = 0;
    int cycles;

    instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .opcode(opcode), .argc(argc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_pc(instr_pc), .instr_argc(instr_argc),
        .instr_args(instr_args), .branch_taken(branch_taken),
        .branch_offset(branch_offset)
    );

    instr_fetch #(.ADDR_WIDTH(4), .RESET_PC(4'hE)) dut_b (
        .clk(clk), .rst(rst_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .opcode(opcode_b), .argc(argc_b), .instr_valid(instr_valid_b),
        .instr_ready(instr_ready_b), .instr_pc(instr_pc_b), .instr_argc(instr_argc_b),
        .instr_args(instr_args_b), .branch_taken(branch_taken_b),
        .branch_offset(branch_offset_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decoder model: BIPUSH=1 arg, SIPUSH/GOTO=2 args, 0x13 reports undefined 3.
    function automatic logic [1:0] argc_of(input logic [7:0] op);
        case (op)
            8'h10:        return 2'd1;
            8'h11, 8'hA7: return 2'd2;
            8'h13:        return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

    assign argc   = argc_of(opcode);
    assign argc_b = argc_of(opcode_b);

    always @(posedge clk) begin
        mem_rdata   <= mem_a[mem_addr[7:0]];
        mem_rdata_b <= mem_b[mem_addr_b];
    end

    // NOTE: outputs are sampled on the falling edge, half a cycle clear of the
    // rising edge where the DUT updates.
    task automatic step_to_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
    endtask

    task automatic test_reset;
        @(negedge clk);
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 16'h0100;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %h want 00", opcode); end
        checks++; if (instr_args !== 16'h0000) begin errors++; $display("FAIL reset_args: got %h want 0000", instr_args); end
        checks++; if (instr_argc !== 2'd0) begin errors++; $display("FAIL reset_argc: got %0d want 0", instr_argc); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
        branch_taken = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_nop;
        step_to_valid(cycles);
        checks++; if (cycles !== 3) begin errors++; $display("FAIL nop_latency: got %0d want 3", cycles); end
        checks++; if (opcode !== 8'h00) begin errors++; $display("FAIL nop_opcode: got %h want 00", opcode); end
        checks++; if (instr_args !== 16'h0000) begin errors++; $display("FAIL nop_args: got %h want 0000", instr_args); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL nop_pc: got %h want 0000", instr_pc); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0001) begin errors++; $display("FAIL nop_next_addr: got %h want 0001", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL nop_valid_drop: got %b want 0", instr_valid); end
    endtask

    task automatic test_bipush;
        step_to_valid(cycles);
        checks++; if (cycles !== 3) begin errors++; $display("FAIL bipush_latency: got %0d want 3", cycles); end
        checks++; if (opcode !== 8'h10) begin errors++; $display("FAIL bipush_opcode: got %h want 10", opcode); end
        checks++; if (instr_argc !== 2'd1) begin errors++; $display("FAIL bipush_argc: got %0d want 1", instr_argc); end
        checks++; if (instr_args !== 16'h002A) begin errors++; $display("FAIL bipush_args: got %h want 002a", instr_args); end
        checks++; if (instr_pc !== 16'h0001) begin errors++; $display("FAIL bipush_pc: got %h want 0001", instr_pc); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0003) begin errors++; $display("FAIL bipush_next_addr: got %h want 0003", mem_addr); end
    endtask

    task automatic test_sipush;
        checks++; if (mem_addr !== 16'h0003) begin errors++; $display("FAIL sipush_opreq_addr: got %h want 0003", mem_addr); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0004) begin errors++; $display("FAIL sipush_opcap_addr: got %h want 0004", mem_addr); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0005) begin errors++; $display("FAIL sipush_dec_addr: got %h want 0005", mem_addr); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0003) begin errors++; $display("FAIL sipush_arg2_addr: got %h want 0003", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL sipush_arg2_valid: got %b want 0", instr_valid); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL sipush_latency4_valid: got %b want 1", instr_valid); end
        checks++; if (instr_args !== 16'h1234) begin errors++; $display("FAIL sipush_args: got %h want 1234", instr_args); end
        checks++; if (instr_argc !== 2'd2) begin errors++; $display("FAIL sipush_argc: got %0d want 2", instr_argc); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0006) begin errors++; $display("FAIL sipush_next_addr: got %h want 0006", mem_addr); end
    endtask

    task automatic test_branch;
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFA;
        step_to_valid(cycles);
        checks++; if (cycles !== 4) begin errors++; $display("FAIL goto_latency: got %0d want 4", cycles); end
        checks++; if (opcode !== 8'hA7) begin errors++; $display("FAIL goto_opcode: got %h want a7", opcode); end
        checks++; if (instr_pc !== 16'h0006) begin errors++; $display("FAIL goto_pc: got %h want 0006", instr_pc); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL goto_target_addr: got %h want 0000", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL goto_valid_drop: got %b want 0", instr_valid); end
        branch_taken = 1'b0;
    endtask

    task automatic test_backpressure;
        instr_ready = 1'b0;
        step_to_valid(cycles);
        checks++; if (cycles !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", cycles); end
        branch_taken  = 1'b1;
        branch_offset = 16'h0055;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, instr_valid); end
            checks++; if ({opcode, instr_args, instr_pc, mem_addr} !== {8'h00, 16'h0000, 16'h0000, 16'h0000})
                begin errors++; $display("FAIL bp_hold_outputs[%0d]: got %h/%h/%h/%h want 00/0000/0000/0000", i, opcode, instr_args, instr_pc, mem_addr); end
        end
        instr_ready   = 1'b1;
        branch_offset = 16'h0010;
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL bp_accept_addr: got %h want 0010", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_valid: got %b want 0", instr_valid); end
        branch_taken  = 1'b0;
        branch_offset = 16'h1234;
    endtask

    task automatic test_undef_argc;
        step_to_valid(cycles);
        checks++; if (cycles !== 3) begin errors++; $display("FAIL undef_latency: got %0d want 3", cycles); end
        checks++; if (opcode !== 8'h13) begin errors++; $display("FAIL undef_opcode: got %h want 13", opcode); end
        checks++; if (instr_argc !== 2'd0) begin errors++; $display("FAIL undef_argc: got %0d want 0", instr_argc); end
        checks++; if (instr_args !== 16'h0000) begin errors++; $display("FAIL undef_args: got %h want 0000", instr_args); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0011) begin errors++; $display("FAIL undef_next_addr: got %h want 0011", mem_addr); end
    endtask

    task automatic test_reset_arg2_wrap;
        @(negedge clk);
        checks++; if (mem_addr_b !== 4'hE) begin errors++; $display("FAIL wrap_reset_addr: got %h want e", mem_addr_b); end
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (mem_addr_b !== 4'hF) begin errors++; $display("FAIL wrap_opcap_addr: got %h want f", mem_addr_b); end
        @(negedge clk);
        checks++; if (mem_addr_b !== 4'h0) begin errors++; $display("FAIL wrap_dec_addr: got %h want 0", mem_addr_b); end
        @(negedge clk);
        checks++; if (opcode_b !== 8'h11) begin errors++; $display("FAIL wrap_arg2_opcode: got %h want 11", opcode_b); end
        #2 rst_b = 1'b1;
        #1;
        checks++; if (instr_valid_b !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", instr_valid_b); end
        checks++; if (mem_addr_b !== 4'hE) begin errors++; $display("FAIL midreset_addr: got %h want e", mem_addr_b); end
        checks++; if (opcode_b !== 8'h00) begin errors++; $display("FAIL midreset_opcode: got %h want 00", opcode_b); end
        checks++; if (instr_args_b !== 16'h0000) begin errors++; $display("FAIL midreset_args: got %h want 0000", instr_args_b); end
        @(negedge clk);
        rst_b = 1'b0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!instr_valid_b && cycles < 20);
        checks++; if (cycles !== 4) begin errors++; $display("FAIL wrap_latency: got %0d want 4", cycles); end
        checks++; if (instr_args_b !== 16'hABCD) begin errors++; $display("FAIL wrap_args: got %h want abcd", instr_args_b); end
        checks++; if (instr_pc_b !== 4'hE) begin errors++; $display("FAIL wrap_pc: got %h want e", instr_pc_b); end
        @(negedge clk);
        checks++; if (mem_addr_b !== 4'h1) begin errors++; $display("FAIL wrap_next_addr: got %h want 1", mem_addr_b); end
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!instr_valid_b && cycles < 20);
        checks++; if (instr_pc_b !== 4'h1 || cycles !== 3) begin errors++; $display("FAIL wrap_nop: got pc %h lat %0d want pc 1 lat 3", instr_pc_b, cycles); end
    endtask

    initial begin
        rst             = 1'b1;
        rst_b           = 1'b1;
        instr_ready     = 1'b0;
        branch_taken    = 1'b0;
        branch_offset   = 16'h0000;
        instr_ready_b   = 1'b1;
        branch_taken_b  = 1'b0;
        branch_offset_b = 16'h0000;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 16; i++)  mem_b[i] = 8'h00;
        mem_a[1]  = 8'h10; mem_a[2]  = 8'h2A;
        mem_a[3]  = 8'h11; mem_a[4]  = 8'h12; mem_a[5] = 8'h34;
        mem_a[6]  = 8'hA7; mem_a[7]  = 8'hFF; mem_a[8] = 8'hFA;
        mem_a[16] = 8'h13; mem_a[17] = 8'h77;
        mem_b[14] = 8'h11; mem_b[15] = 8'hAB; mem_b[0] = 8'hCD;

        test_reset;
        test_nop;
        test_bipush;
        test_sipush;
        test_branch;
        test_backpressure;
        test_undef_argc;
        test_reset_arg2_wrap;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
